// File: rtl/miss_stall_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// miss_stall_ctrl_pkg
// Shared definitions for the MEM-stage cache-miss sequencer:
//   - state_e              : sequencer state encoding (2 bits)
//   - DEFAULT_WORDS_PER_LINE: default refill beats per cache line
//   - lineOffsetBits()     : number of low address bits that select a byte
//                            within a cache line (byte-in-word + word-in-line)
// ----------------------------------------------------------------------------
package miss_stall_ctrl_pkg;

    localparam int DEFAULT_WORDS_PER_LINE = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ    = 2'd1,
        S_REFILL = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    // Bits to clear from a byte address to get the line-aligned address.
    function automatic int lineOffsetBits(input int wordsPerLine, input int dataW);
        return $clog2(dataW / 8) + $clog2(wordsPerLine);
    endfunction

endpackage

// File: rtl/miss_stall_ctrl_refill_beat_ctr.sv
// ----------------------------------------------------------------------------
// refill_beat_ctr
// Word counter for a cache-line refill. Counts accepted refill beats, wraps to
// zero after the last word of the line and flags when the current count is
// the last word index.
// Ports:
//   clk_i     : rising-edge clock
//   rst_i     : synchronous active-high reset (count -> 0)
//   clear_i   : restart the count at 0 (start of a refill)
//   advance_i : one refill beat accepted this cycle
//   count_o   : current word index
//   last_o    : count_o == WORDS_PER_LINE-1
// ----------------------------------------------------------------------------
module refill_beat_ctr
    import miss_stall_ctrl_pkg::*;
#(
    parameter int WORDS_PER_LINE = DEFAULT_WORDS_PER_LINE,
    parameter int IDX_W          = $clog2(WORDS_PER_LINE)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             advance_i,
    output logic [IDX_W-1:0] count_o,
    output logic             last_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_LINE - 1);

    logic [IDX_W-1:0] count_q;
    logic [IDX_W-1:0] count_d;

    // Explicit wrap keeps the intent clear even though the line size is a
    // power of two and the adder would overflow to zero anyway.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (advance_i) begin
            count_d = last_o ? '0 : count_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign last_o  = (count_q == LAST_IDX);

endmodule

// File: rtl/miss_stall_ctrl.sv
// ----------------------------------------------------------------------------
// miss_stall_ctrl
// MEM-stage cache-miss sequencer. On a load/store miss it freezes the
// pipeline registers (pipe_en_o low), requests the line from main memory,
// writes the returned words into the cache data array and then pulses
// line_fill_o for one cycle before releasing the pipeline.
//
// Optional feature (macro MISS_STALL_PERF_EN):
//   stall_cycles_o : saturating count of cycles with pipe_en_o==0 outside reset
//   miss_count_o   : saturating count of IDLE->REQ transitions
//
// Ports:
//   clk_i, rst_i            : clock, synchronous active-high reset
//   mem_access_i            : valid load/store in MEM this cycle
//   cache_hit_i             : combinational tag-compare result
//   access_addr_i           : byte address of the access
//   pipe_en_o               : pipeline register advance enable
//   busy_o                  : sequencer not idle
//   mem_req_o, mem_addr_o   : line refill request and line-aligned address
//   mem_gnt_i               : request accepted
//   mem_rvalid_i, mem_rdata_i : refill word stream
//   refill_we_o, refill_idx_o, refill_data_o : data-array write port
//   line_fill_o             : set valid bit / write tag of the refilled line
// ----------------------------------------------------------------------------
module miss_stall_ctrl
    import miss_stall_ctrl_pkg::*;
#(
    parameter int WORDS_PER_LINE = DEFAULT_WORDS_PER_LINE,
    parameter int IDX_W          = $clog2(WORDS_PER_LINE),
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              mem_access_i,
    input  logic              cache_hit_i,
    input  logic [ADDR_W-1:0] access_addr_i,
    output logic              pipe_en_o,
    output logic              busy_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              refill_we_o,
    output logic [IDX_W-1:0]  refill_idx_o,
    output logic [DATA_W-1:0] refill_data_o,
    output logic              line_fill_o
`ifdef MISS_STALL_PERF_EN
    ,
    output logic [31:0]       stall_cycles_o,
    output logic [31:0]       miss_count_o
`endif
);

    localparam int OFFSET_W = lineOffsetBits(WORDS_PER_LINE, DATA_W);
    localparam logic [ADDR_W-1:0] LINE_MASK =
        ~((ADDR_W'(1) << OFFSET_W) - ADDR_W'(1));

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              refill_we_q, refill_we_d;
    logic [IDX_W-1:0]  refill_idx_q, refill_idx_d;
    logic [DATA_W-1:0] refill_data_q, refill_data_d;

    logic              miss;
    logic              beatClear;
    logic              beatAdvance;
    logic [IDX_W-1:0]  beatCount;
    logic              beatLast;

    assign miss = mem_access_i & ~cache_hit_i;

    assign beatClear   = (state_q == S_REQ) & mem_gnt_i;
    assign beatAdvance = (state_q == S_REFILL) & mem_rvalid_i;

    refill_beat_ctr #(
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .IDX_W          (IDX_W)
    ) u_beat_ctr (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (beatClear),
        .advance_i (beatAdvance),
        .count_o   (beatCount),
        .last_o    (beatLast)
    );

    // Next-state and refill write-port logic. Index/data hold their last
    // value in gap cycles; only the write strobe drops.
    always_comb begin
        state_d       = state_q;
        mem_addr_d    = mem_addr_q;
        refill_we_d   = 1'b0;
        refill_idx_d  = refill_idx_q;
        refill_data_d = refill_data_q;

        case (state_q)
            S_IDLE: begin
                if (miss) begin
                    state_d    = S_REQ;
                    mem_addr_d = access_addr_i & LINE_MASK;
                end
            end
            S_REQ: begin
                if (mem_gnt_i) begin
                    state_d = S_REFILL;
                end
            end
            S_REFILL: begin
                if (mem_rvalid_i) begin
                    refill_we_d   = 1'b1;
                    refill_idx_d  = beatCount;
                    refill_data_d = mem_rdata_i;
                    if (beatLast) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Reset abandons any in-flight request or refill; line_fill is derived
    // from the state, so a partially written line is never marked valid.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            mem_addr_q    <= '0;
            refill_we_q   <= 1'b0;
            refill_idx_q  <= '0;
            refill_data_q <= '0;
        end else begin
            state_q       <= state_d;
            mem_addr_q    <= mem_addr_d;
            refill_we_q   <= refill_we_d;
            refill_idx_q  <= refill_idx_d;
            refill_data_q <= refill_data_d;
        end
    end

    // pipe_en drops combinationally in the very cycle a miss is seen so the
    // pipeline never slips past the missing access.
    assign pipe_en_o     = (state_q == S_IDLE) & ~miss & ~rst_i;
    assign busy_o        = (state_q != S_IDLE);
    assign mem_req_o     = (state_q == S_REQ);
    assign mem_addr_o    = mem_addr_q;
    assign refill_we_o   = refill_we_q;
    assign refill_idx_o  = refill_idx_q;
    assign refill_data_o = refill_data_q;
    assign line_fill_o   = (state_q == S_DONE);

`ifdef MISS_STALL_PERF_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] miss_count_q;

    // Both counters saturate rather than wrap so long runs stay meaningful.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cycles_q <= '0;
            miss_count_q   <= '0;
        end else begin
            if (!pipe_en_o && (stall_cycles_q != 32'hFFFF_FFFF)) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
            if ((state_q == S_IDLE) && (state_d == S_REQ) &&
                (miss_count_q != 32'hFFFF_FFFF)) begin
                miss_count_q <= miss_count_q + 32'd1;
            end
        end
    end

    assign stall_cycles_o = stall_cycles_q;
    assign miss_count_o   = miss_count_q;
`endif

endmodule

// File: tb/tb_miss_stall_ctrl.sv
// ----------------------------------------------------------------------------
// tb_miss_stall_ctrl
// Directed self-checking bench for miss_stall_ctrl (default line of 4 words).
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge.
// ----------------------------------------------------------------------------
module tb_miss_stall_ctrl;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int WPL    = 4;
    localparam int IDX_W  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              mem_access;
    logic              cache_hit;
    logic [ADDR_W-1:0] access_addr;
    logic              pipe_en;
    logic              busy;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;
    logic              refill_we;
    logic [IDX_W-1:0]  refill_idx;
    logic [DATA_W-1:0] refill_data;
    logic              line_fill;
`ifdef MISS_STALL_PERF_EN
    logic [31:0]       stall_cycles;
    logic [31:0]       miss_count;
`endif

    int totalChecks = 0;
    int badChecks   = 0;

    always #5 clk = ~clk;

    miss_stall_ctrl #(
        .WORDS_PER_LINE (WPL),
        .IDX_W          (IDX_W),
        .ADDR_W         (ADDR_W),
        .DATA_W         (DATA_W)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .mem_access_i  (mem_access),
        .cache_hit_i   (cache_hit),
        .access_addr_i (access_addr),
        .pipe_en_o     (pipe_en),
        .busy_o        (busy),
        .mem_req_o     (mem_req),
        .mem_addr_o    (mem_addr),
        .mem_gnt_i     (mem_gnt),
        .mem_rvalid_i  (mem_rvalid),
        .mem_rdata_i   (mem_rdata),
        .refill_we_o   (refill_we),
        .refill_idx_o  (refill_idx),
        .refill_data_o (refill_data),
        .line_fill_o   (line_fill)
`ifdef MISS_STALL_PERF_EN
        ,
        .stall_cycles_o (stall_cycles),
        .miss_count_o   (miss_count)
`endif
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic access, input logic hit,
                                 input logic [31:0] addr, input logic gnt,
                                 input logic rvalid, input logic [31:0] rdata);
        mem_access  = access;
        cache_hit   = hit;
        access_addr = addr;
        mem_gnt     = gnt;
        mem_rvalid  = rvalid;
        mem_rdata   = rdata;
    endtask

    task automatic nextCycle;
        @(posedge clk);
        #1;
    endtask

    task automatic sampleNow;
        @(negedge clk);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".pipe_en"},     64'(pipe_en),     64'd0);
        checkOutput({tag, ".busy"},        64'(busy),        64'd0);
        checkOutput({tag, ".mem_req"},     64'(mem_req),     64'd0);
        checkOutput({tag, ".mem_addr"},    64'(mem_addr),    64'd0);
        checkOutput({tag, ".refill_we"},   64'(refill_we),   64'd0);
        checkOutput({tag, ".refill_idx"},  64'(refill_idx),  64'd0);
        checkOutput({tag, ".refill_data"}, 64'(refill_data), 64'd0);
        checkOutput({tag, ".line_fill"},   64'(line_fill),   64'd0);
    endtask

    // One full miss: miss cycle, REQ (grant on cycle gntWait), REFILL with the
    // given rvalid pattern (bit j = cycle j, must hold exactly 4 ones, last
    // bit set), DONE, then a hit on re-lookup. expStall is the number of
    // pipe_en-low cycles after the miss cycle, up to and including DONE.
    task automatic doMiss(input string tag, input logic [31:0] addr,
                          input logic [31:0] expAddr, input int gntWait,
                          input logic [15:0] pattern, input int patLen,
                          input logic [31:0] dataBase, input int expStall);
        int   lowCycles = 0;
        int   beat      = 0;
        int   prevBeat  = 0;
        logic prevValid = 1'b0;
        logic v;

        applyStimulus(1'b1, 1'b0, addr, 1'b0, 1'b0, 32'h0);
        sampleNow();
        checkOutput({tag, ".missPipeEn"}, 64'(pipe_en), 64'd0);
        checkOutput({tag, ".missBusy"},   64'(busy),    64'd0);
        nextCycle();

        // Stray rvalid during REQ must never write the data array.
        for (int i = 0; i <= gntWait; i++) begin
            applyStimulus(1'b1, 1'b0, addr, (i == gntWait), 1'b1, 32'hDEAD_0000 + i);
            sampleNow();
            checkOutput({tag, ".reqMemReq"}, 64'(mem_req),   64'd1);
            checkOutput({tag, ".reqAddr"},   64'(mem_addr),  64'(expAddr));
            checkOutput({tag, ".reqNoWe"},   64'(refill_we), 64'd0);
            if (!pipe_en) lowCycles++;
            nextCycle();
        end

        for (int j = 0; j < patLen; j++) begin
            v = pattern[j];
            applyStimulus(1'b1, 1'b0, addr, 1'b0, v, dataBase + beat);
            sampleNow();
            checkOutput({tag, ".fillWe"},  64'(refill_we), 64'(prevValid));
            checkOutput({tag, ".fillReq"}, 64'(mem_req),   64'd0);
            if (prevValid) begin
                checkOutput({tag, ".fillIdx"},  64'(refill_idx),  64'(prevBeat));
                checkOutput({tag, ".fillData"}, 64'(refill_data), 64'(dataBase + prevBeat));
            end
            if (!pipe_en) lowCycles++;
            nextCycle();
            prevValid = v;
            if (v) begin
                prevBeat = beat;
                beat++;
            end
        end

        // DONE: cache already reports a hit, but the pipe stays frozen.
        applyStimulus(1'b1, 1'b1, addr, 1'b0, 1'b0, 32'h0);
        sampleNow();
        checkOutput({tag, ".doneLineFill"}, 64'(line_fill),   64'd1);
        checkOutput({tag, ".doneWe"},       64'(refill_we),   64'd1);
        checkOutput({tag, ".doneIdx"},      64'(refill_idx),  64'(WPL - 1));
        checkOutput({tag, ".doneData"},     64'(refill_data), 64'(dataBase + WPL - 1));
        checkOutput({tag, ".donePipeEn"},   64'(pipe_en),     64'd0);
        if (!pipe_en) lowCycles++;
        nextCycle();

        sampleNow();
        checkOutput({tag, ".relookPipeEn"}, 64'(pipe_en),   64'd1);
        checkOutput({tag, ".relookBusy"},   64'(busy),      64'd0);
        checkOutput({tag, ".relookFill"},   64'(line_fill), 64'd0);
        checkOutput({tag, ".relookWe"},     64'(refill_we), 64'd0);
        checkOutput({tag, ".stallLen"},     64'(lowCycles), 64'(expStall));
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        nextCycle();
        nextCycle();
        sampleNow();
        checkAllZero("reset");
        nextCycle();
        rst = 1'b0;

        // Hit path: pipeline advances every cycle, no memory traffic.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'b1, 32'h0000_0100 + 32'(i * 4), 1'b0, 1'b0, 32'h0);
            sampleNow();
            checkOutput("hit.pipeEn", 64'(pipe_en), 64'd1);
            checkOutput("hit.memReq", 64'(mem_req), 64'd0);
            nextCycle();
        end

        // Basic miss: grant on the 4th REQ cycle, 4 back-to-back beats.
        doMiss("basic", 32'h0000_1234, 32'h0000_1230, 3, 16'b1111, 4, 32'h0000_00A0, 9);

        // Gapped refill: rvalid 1,0,0,1,1,0,1 with immediate grant.
        doMiss("gapped", 32'h0000_ABFC, 32'h0000_ABF0, 0, 16'b1011001, 7, 32'h0000_00B0, 9);

        // Stray handshakes while idle.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h5555_5555);
            sampleNow();
            checkOutput("stray.we",     64'(refill_we), 64'd0);
            checkOutput("stray.busy",   64'(busy),      64'd0);
            checkOutput("stray.memReq", 64'(mem_req),   64'd0);
            checkOutput("stray.pipeEn", 64'(pipe_en),   64'd1);
            nextCycle();
        end

        // Reset after two beats of a refill.
        applyStimulus(1'b1, 1'b0, 32'h0000_200C, 1'b0, 1'b0, 32'h0);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 32'h0000_200C, 1'b1, 1'b0, 32'h0);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 32'h0000_200C, 1'b0, 1'b1, 32'h0000_00E0);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 32'h0000_200C, 1'b0, 1'b1, 32'h0000_00E1);
        nextCycle();
        sampleNow();
        checkOutput("midRst.preWe",  64'(refill_we),  64'd1);
        checkOutput("midRst.preIdx", 64'(refill_idx), 64'd1);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_00E2);
        nextCycle();
        sampleNow();
        checkAllZero("midRst");
        nextCycle();
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        nextCycle();
        doMiss("afterRst", 32'h0000_2008, 32'h0000_2000, 0, 16'b1111, 4, 32'h0000_00C0, 6);

`ifdef MISS_STALL_PERF_EN
        rst = 1'b1;
        nextCycle();
        nextCycle();
        rst = 1'b0;
        nextCycle();
        sampleNow();
        checkOutput("perf.stallReset", 64'(stall_cycles), 64'd0);
        checkOutput("perf.missReset",  64'(miss_count),   64'd0);
        nextCycle();
        doMiss("perf1", 32'h0000_3004, 32'h0000_3000, 2, 16'b1111, 4, 32'h0000_0010, 8);
        doMiss("perf2", 32'h0000_4010, 32'h0000_4010, 2, 16'b1111, 4, 32'h0000_0020, 8);
        sampleNow();
        checkOutput("perf.missCount",   64'(miss_count),   64'd2);
        checkOutput("perf.stallCycles", 64'(stall_cycles), 64'd18);
`endif

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
